// File: rtl/sar_seq_ctrl_if.sv
// rtl/sar_seq_ctrl_if.sv - result stream handshake between sar_seq_ctrl and downstream logic
interface sar_seq_ctrl_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/sar_seq_ctrl.sv
// rtl/sar_seq_ctrl.sv - SAR ADC conversion sequencer and result collector
// Optional block averaging is built only when SAR_SEQ_OVERSAMPLE_EN is defined.
module sar_seq_ctrl #(
  parameter int GAP_W    = 8,
  parameter int AVG_LOG2 = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [GAP_W-1:0] period_i,
  input  logic             clr_i,
  output logic             start_o,
  input  logic             rdy_i,
  input  logic [7:0]       dac_i,
  sar_seq_ctrl_if.master   out_if,
  output logic             ovr_o,
  output logic             tmo_o
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;

  state_t           state_q;
  logic [4:0]       tmo_cnt_q;
  logic [GAP_W-1:0] gap_q;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             start_q;
  logic             ovr_q;
  logic             tmo_q;

  logic             capture;
  logic             timeout_ev;
  logic             res_vld;
  logic [7:0]       res_data;

  assign capture    = (state_q == S_WAIT) && rdy_i;
  assign timeout_ev = (state_q == S_WAIT) && !rdy_i && (tmo_cnt_q == 5'd31);

`ifdef SAR_SEQ_OVERSAMPLE_EN
  localparam int ACC_W = 8 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [ACC_W-1:0] acc_sum;
  logic [ACC_W-1:0] avg_full;
  logic             blk_done;

  always_comb begin
    acc_sum  = acc_q + ACC_W'(dac_i);
    avg_full = acc_sum >> AVG_LOG2;
    blk_done = capture && (cnt_q == CNT_LAST);
    res_vld  = blk_done;
    res_data = avg_full[7:0];
  end

  // A partial block never survives a return to IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (state_q == S_IDLE) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (blk_done) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (capture) begin
      acc_q <= acc_sum;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
`else
  logic [31:0] unused_avg_log2;
  assign unused_avg_log2 = AVG_LOG2;

  always_comb begin
    res_vld  = capture;
    res_data = dac_i;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      tmo_cnt_q <= '0;
      gap_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      start_q   <= 1'b0;
      ovr_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (en_i) begin
            state_q <= S_START;
            start_q <= 1'b1;
          end
        end
        S_START: begin
          state_q   <= S_WAIT;
          tmo_cnt_q <= '0;
        end
        S_WAIT: begin
          if (rdy_i || (tmo_cnt_q == 5'd31)) begin
            state_q <= S_GAP;
            gap_q   <= period_i;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 5'd1;
          end
        end
        default: begin
          if (!en_i) begin
            state_q <= S_IDLE;
          end else if (gap_q == '0) begin
            state_q <= S_START;
            start_q <= 1'b1;
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end
      endcase

      // A stalled word is kept; the newer result is the one lost.
      if (res_vld) begin
        if (!valid_q || out_if.ready) begin
          data_q  <= res_data;
          valid_q <= 1'b1;
        end
      end else if (valid_q && out_if.ready) begin
        valid_q <= 1'b0;
      end

      if (res_vld && valid_q && !out_if.ready) ovr_q <= 1'b1;
      else if (clr_i)                          ovr_q <= 1'b0;

      if (timeout_ev) tmo_q <= 1'b1;
      else if (clr_i) tmo_q <= 1'b0;
    end
  end

  assign start_o      = start_q;
  assign out_if.data  = data_q;
  assign out_if.valid = valid_q;
  assign ovr_o        = ovr_q;
  assign tmo_o        = tmo_q;

endmodule
